// File: rtl/logic_unit.sv
// Four-function bitwise logic unit: combinational result plus a registered,
// valid-qualified stage with zero/parity flags and a saturating op counter.
module logic_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             parity_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_cnt
);

  // Every op code is defined, so the result never goes X for 2-state inputs.
  always_comb begin
    result = '0;
    unique case (op)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = a ^ b;
      2'b11: result = ~a;
      default: result = '0;
    endcase
  end

  logic cnt_sat;
  assign cnt_sat = &op_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      parity_q  <= 1'b0;
      out_valid <= 1'b0;
      op_cnt    <= '0;
    end else if (in_valid) begin
      result_q  <= result;
      zero_q    <= (result == '0);
      parity_q  <= ^result;
      out_valid <= 1'b1;
      if (!cnt_sat) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// Directed self-checking bench for logic_unit: combinational functions,
// registered stage, asynchronous reset and counter saturation.
module tb_logic_unit;

  logic [3:0]  a, b, result, result_q, result_s, result_q_s;
  logic [1:0]  op;
  logic        clk, rst, in_valid, in_valid_s;
  logic        zero_q, parity_q, out_valid;
  logic        zero_q_s, parity_q_s, out_valid_s;
  logic [15:0] op_cnt;
  logic [1:0]  op_cnt_s;

  int tests_run = 0;
  int tests_failed = 0;

  logic_unit #(.WIDTH(4), .CNT_W(16)) u_dut (
    .a(a), .b(b), .op(op), .result(result), .clk(clk), .rst(rst),
    .in_valid(in_valid), .result_q(result_q), .zero_q(zero_q),
    .parity_q(parity_q), .out_valid(out_valid), .op_cnt(op_cnt)
  );

  logic_unit #(.WIDTH(4), .CNT_W(2)) u_sat (
    .a(a), .b(b), .op(op), .result(result_s), .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .result_q(result_q_s), .zero_q(zero_q_s),
    .parity_q(parity_q_s), .out_valid(out_valid_s), .op_cnt(op_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, zero_q, parity_q, out_valid, op_cnt} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_main: got q=%b z=%b p=%b v=%b cnt=%0d, want all 0",
               result_q, zero_q, parity_q, out_valid, op_cnt);
    end
    tests_run++;
    if ({out_valid_s, op_cnt_s} !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_sat: got v=%b cnt=%0d, want 0", out_valid_s, op_cnt_s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Shared shape for the three two-operand functions: table of a, b, expected.
  task automatic test_and();
    logic [3:0] av[5] = '{4'b1100, 4'b1111, 4'b0011, 4'b1001, 4'b0000};
    logic [3:0] bv[5] = '{4'b1010, 4'b0101, 4'b0110, 4'b1001, 4'b1111};
    logic [3:0] ev[5] = '{4'b1000, 4'b0101, 4'b0010, 4'b1001, 4'b0000};
    op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      a = av[i]; b = bv[i];
      #1;
      tests_run++;
      if (result !== ev[i]) begin
        tests_failed++;
        $display("FAIL and[%0d]: got %b want %b", i, result, ev[i]);
      end
    end
  endtask

  task automatic test_or();
    logic [3:0] av[5] = '{4'b1100, 4'b0001, 4'b0000, 4'b1010, 4'b0110};
    logic [3:0] bv[5] = '{4'b1010, 4'b0010, 4'b0000, 4'b0101, 4'b0100};
    logic [3:0] ev[5] = '{4'b1110, 4'b0011, 4'b0000, 4'b1111, 4'b0110};
    op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      a = av[i]; b = bv[i];
      #1;
      tests_run++;
      if (result !== ev[i]) begin
        tests_failed++;
        $display("FAIL or[%0d]: got %b want %b", i, result, ev[i]);
      end
    end
  endtask

  task automatic test_xor();
    logic [3:0] av[5] = '{4'b1100, 4'b1111, 4'b0011, 4'b1000, 4'b0110};
    logic [3:0] bv[5] = '{4'b1010, 4'b0101, 4'b0011, 4'b0001, 4'b1100};
    logic [3:0] ev[5] = '{4'b0110, 4'b1010, 4'b0000, 4'b1001, 4'b1010};
    op = 2'b10;
    for (int i = 0; i < 5; i++) begin
      a = av[i]; b = bv[i];
      #1;
      tests_run++;
      if (result !== ev[i]) begin
        tests_failed++;
        $display("FAIL xor[%0d]: got %b want %b", i, result, ev[i]);
      end
    end
  endtask

  task automatic test_not();
    logic [3:0] av[4] = '{4'b0000, 4'b1111, 4'b1010, 4'b0110};
    logic [3:0] ev[4] = '{4'b1111, 4'b0000, 4'b0101, 4'b1001};
    int bad = 0;
    op = 2'b11;
    a = 4'b1100;
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      #1;
      if (result !== 4'b0011) begin
        bad++;
        $display("FAIL not_sweep b=%b: got %b want 0011", b, result);
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    b = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      a = av[i];
      #1;
      tests_run++;
      if (result !== ev[i]) begin
        tests_failed++;
        $display("FAIL not[%0d]: got %b want %b", i, result, ev[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    op = 2'b10; a = 4'b0101; b = 4'b0101; in_valid = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, zero_q, parity_q, out_valid, op_cnt} !== {4'b0000, 1'b1, 1'b0, 1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL reg_capture: got q=%b z=%b p=%b v=%b cnt=%0d, want 0000 1 0 1 1",
               result_q, zero_q, parity_q, out_valid, op_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 4'b1110;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, zero_q, out_valid, op_cnt} !== {4'b0000, 1'b1, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL reg_idle: got q=%b z=%b v=%b cnt=%0d, want 0000 1 0 1",
               result_q, zero_q, out_valid, op_cnt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = 2'b01; a = 4'b0111; b = 4'b0000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, zero_q, parity_q, out_valid, op_cnt} !== {4'b0111, 1'b0, 1'b1, 1'b1, 16'd2}) begin
      tests_failed++;
      $display("FAIL b2b_first: got q=%b z=%b p=%b v=%b cnt=%0d, want 0111 0 1 1 2",
               result_q, zero_q, parity_q, out_valid, op_cnt);
    end
    @(negedge clk);
    op = 2'b00; a = 4'b1111; b = 4'b0011;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, zero_q, parity_q, out_valid, op_cnt} !== {4'b0011, 1'b0, 1'b0, 1'b1, 16'd3}) begin
      tests_failed++;
      $display("FAIL b2b_second: got q=%b z=%b p=%b v=%b cnt=%0d, want 0011 0 0 1 3",
               result_q, zero_q, parity_q, out_valid, op_cnt);
    end
  endtask

  task automatic test_reset_mid();
    // in_valid is still 1 from the back-to-back scenario
    @(negedge clk);
    op = 2'b11; a = 4'b0001;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({result_q, zero_q, parity_q, out_valid, op_cnt} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got q=%b z=%b p=%b v=%b cnt=%0d, want all 0",
               result_q, zero_q, parity_q, out_valid, op_cnt);
    end
    a = 4'b1001;
    #1;
    tests_run++;
    if (result !== 4'b0110) begin
      tests_failed++;
      $display("FAIL reset_comb: got %b want 0110", result);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, out_valid, op_cnt} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_discard: got q=%b v=%b cnt=%0d, want 0", result_q, out_valid, op_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({result_q, out_valid, op_cnt} !== {4'b0110, 1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL reset_first: got q=%b v=%b cnt=%0d, want 0110 1 1",
               result_q, out_valid, op_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] ev[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    in_valid_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (op_cnt_s !== ev[i] || out_valid_s !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat[%0d]: got cnt=%0d v=%b want cnt=%0d v=1",
                 i, op_cnt_s, out_valid_s, ev[i]);
      end
    end
    @(negedge clk);
    in_valid_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0;
    a = '0; b = '0; op = '0;
    test_reset();
    test_and();
    test_or();
    test_xor();
    test_not();
    test_registered();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
